instruction_decoder: RTL and testbench

- Microcoded control-signal generator for the simple CPU datapath.
- Decodes the 8-bit instruction register `ir` together with the 3-bit instruction cycle counter `cycle` into an 8-bit registered control word `ctrl_sig1`.
- Sits between the IR/cycle sequencer and the datapath (memory, ALU, accumulator, PC).
- Updates only on phase-2-qualified system clock edges.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/instr_decode_rom.sv | 43 ++++
 rtl/instruction_decoder.sv | 40 ++++
 tb/tb_instruction_decoder.sv | 89 ++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode and control-bit encodings for the CPU control path.
package cpu_ctrl_pkg;

    typedef logic [7:0] ctrl_word_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_MOVA  = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JMPI  = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'h07;

    localparam int CTL_MEM_RD   = 0;
    localparam int CTL_MEM_WR   = 1;
    localparam int CTL_ACC_LOAD = 2;
    localparam int CTL_ALU_EN   = 3;
    localparam int CTL_REG_WR   = 4;
    localparam int CTL_PC_INC   = 5;
    localparam int CTL_PC_LOAD  = 6;
    localparam int CTL_HALT     = 7;

endpackage

// File: rtl/instr_decode_rom.sv
// Pure combinational opcode x cycle -> control word table.
module instr_decode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0] ir,
    input  logic [2:0] cycle,
    output ctrl_word_t word
);

    always_comb begin
        word = '0;
        case (ir)
            OP_NOP:   if (cycle == 3'd0) word = 8'h20;
            OP_LOAD:  case (cycle)
                          3'd0:    word = 8'h21;
                          3'd1:    word = 8'h18;
                          default: word = '0;
                      endcase
            OP_STORE: case (cycle)
                          3'd0:    word = 8'h02;
                          3'd1:    word = 8'h20;
                          default: word = '0;
                      endcase
            OP_MOVA:  if (cycle == 3'd0) word = 8'h24;
            OP_ADD:   case (cycle)
                          3'd0:    word = 8'h01;
                          3'd1:    word = 8'h0C;
                          3'd2:    word = 8'h20;
                          default: word = '0;
                      endcase
            OP_JMP:   if (cycle == 3'd0) word = 8'h40;
            OP_JMPI:  case (cycle)
                          3'd0:    word = 8'h01;
                          3'd1:    word = 8'h40;
                          default: word = '0;
                      endcase
            OP_HALT:  if (cycle == 3'd0) word = 8'h80;
            // undefined opcodes fall through to an all-zero word
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decoder.sv
// Registered control-word generator; updates only on phase-2-qualified edges.
module instruction_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic       sys_clock,
    input  logic       rst,
    input  logic       clk_ph2,
    input  logic [2:0] cycle,
    input  logic [7:0] ir,
    output logic [7:0] ctrl_sig1
);

    ctrl_word_t rom_word;
    ctrl_word_t ctrl_sig1_d, ctrl_sig1_q;

    instr_decode_rom u_rom (
        .ir    (ir),
        .cycle (cycle),
        .word  (rom_word)
    );

    always_comb begin
        ctrl_sig1_d = ctrl_sig1_q;
        if (clk_ph2) ctrl_sig1_d = rom_word;
    end

    always_ff @(posedge sys_clock) begin
        if (rst) ctrl_sig1_q <= '0;
        else     ctrl_sig1_q <= ctrl_sig1_d;
    end

    always_ff @(posedge sys_clock) begin
        if (!rst)
            assert (!(ctrl_sig1_q[CTL_MEM_RD] && ctrl_sig1_q[CTL_MEM_WR]))
                else $error("mem_rd and mem_wr both set");
    end

    assign ctrl_sig1 = ctrl_sig1_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder.
module tb_instruction_decoder;

    logic       sys_clock = 1'b0;
    logic       rst;
    logic       clk_ph2;
    logic [2:0] cycle;
    logic [7:0] ir;
    logic [7:0] ctrl_sig1;

    int checks = 0;
    int errors = 0;

    instruction_decoder dut (
        .sys_clock (sys_clock),
        .rst       (rst),
        .clk_ph2   (clk_ph2),
        .cycle     (cycle),
        .ir        (ir),
        .ctrl_sig1 (ctrl_sig1)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h exp %02h", tag, got, exp);
        end
    endtask

    // drive inputs, take one rising edge, then compare a little after it
    task automatic step(input logic r, input logic ph2, input logic [7:0] op,
                        input logic [2:0] cyc, input string tag, input logic [7:0] exp);
        rst = r; clk_ph2 = ph2; ir = op; cycle = cyc;
        @(posedge sys_clock);
        #1;
        chk(tag, ctrl_sig1, exp);
    endtask

    initial begin
        rst = 1'b1; clk_ph2 = 1'b1; ir = 8'h01; cycle = 3'd0;
        @(negedge sys_clock);

        step(1, 1, 8'h01, 0, "reset_e1", 8'h00);
        step(1, 1, 8'h01, 0, "reset_e2", 8'h00);
        step(0, 1, 8'h01, 0, "load_c0", 8'h21);
        step(0, 1, 8'h01, 1, "load_c1", 8'h18);
        step(0, 1, 8'h01, 2, "load_c2", 8'h00);
        for (int c = 3; c < 8; c++)
            step(0, 1, 8'h01, 3'(c), "load_hi_cycle", 8'h00);

        step(0, 1, 8'h02, 0, "store_c0", 8'h02);
        step(0, 1, 8'h02, 1, "store_c1", 8'h20);
        step(0, 1, 8'h03, 0, "mova_c0", 8'h24);
        step(0, 1, 8'h03, 1, "mova_c1", 8'h00);
        step(0, 1, 8'h04, 0, "add_c0", 8'h01);
        step(0, 1, 8'h04, 1, "add_c1", 8'h0C);
        step(0, 1, 8'h04, 2, "add_c2", 8'h20);
        step(0, 1, 8'h05, 0, "jmp_c0", 8'h40);
        step(0, 1, 8'h06, 0, "jmpi_c0", 8'h01);
        step(0, 1, 8'h06, 1, "jmpi_c1", 8'h40);
        step(0, 1, 8'h07, 0, "halt_c0", 8'h80);
        step(0, 1, 8'h07, 1, "halt_c1", 8'h00);
        step(0, 1, 8'h00, 0, "nop_c0", 8'h20);
        step(0, 1, 8'h00, 1, "nop_c1", 8'h00);

        for (int c = 0; c < 8; c++)
            step(0, 1, 8'hFF, 3'(c), "undef_ff", 8'h00);
        step(0, 1, 8'h08, 0, "undef_08", 8'h00);

        // phase-2 gating: output must hold while the qualifier is low
        step(0, 1, 8'h01, 0, "gate_pre", 8'h21);
        step(0, 0, 8'h05, 0, "gate_hold1", 8'h21);
        step(0, 0, 8'h05, 0, "gate_hold2", 8'h21);
        step(0, 1, 8'h05, 0, "gate_open", 8'h40);

        // reset wins over a low qualifier mid-instruction
        step(0, 1, 8'h04, 1, "mid_add_c1", 8'h0C);
        step(1, 0, 8'h04, 1, "mid_rst", 8'h00);
        step(0, 0, 8'h04, 1, "post_rst_hold", 8'h00);
        step(0, 1, 8'h04, 1, "post_rst_run", 8'h0C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
